// File: rtl/io_ctrl.sv
// Memory-mapped I/O controller at FFF0..FFFF: debounced KEY/SW, key events, interval timer, LED/HEX registers.
// Define IO_HEXDEC_EN to drive HEX0..3 as four decoded hex digits of HEXR instead of raw segments on HEX0.
module io_ctrl #(
    parameter int DBITS = 16,
    parameter int DEBN  = 500000,
    parameter int TICK  = 50000
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [15:0]      ADDR,
    input  logic [DBITS-1:0] DIN,
    input  logic             WE,
    input  logic             RE,
    output logic [DBITS-1:0] DOUT,
    output logic             SEL,
    input  logic [3:0]       KEY,
    input  logic [9:0]       SW,
    output logic [9:0]       LEDR,
    output logic [7:0]       LEDG,
    output logic [6:0]       HEX0,
    output logic [6:0]       HEX1,
    output logic [6:0]       HEX2,
    output logic [6:0]       HEX3
);

    localparam int DW = (DEBN > 1) ? $clog2(DEBN) : 1;
    localparam int TW = (TICK > 1) ? $clog2(TICK) : 1;
    localparam logic [13:0] IN_RST = {10'b0, 4'hF};

`ifdef IO_HEXDEC_EN
    function automatic logic [6:0] hex_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            4'hF:    s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction
`endif

    // Bits 3:0 carry KEY, bits 13:4 carry SW through one shared debounce path.
    logic [13:0]   raw_s;
    logic [13:0]   sync1_r, sync2_r, deb_r;
    logic [DW-1:0] deb_cnt_r [14];
    logic [13:0]   deb_done_s;
    logic [3:0]    press_s;

    logic          sel_s, wr_s, rd_s;
    logic [2:0]    idx_s;
    logic          kread_s, w1c_s, wr_tcnt_s, wrap_s, twrap_set_s;
    logic          unused_s;

    logic [3:0]       kdata_r;
    logic             kready_r, kovr_r, twrap_r;
    logic [DBITS-1:0] tcnt_r, tlim_r, hexr_r;
    logic [TW-1:0]    presc_r;
    logic [9:0]       ledrr_r;
    logic [7:0]       ledgr_r;
    logic [6:0]       hex0_r, hex1_r, hex2_r, hex3_r;
    logic [DBITS-1:0] dout_s;

    assign raw_s    = {SW, KEY};
    assign sel_s    = (ADDR[15:4] == 12'hFFF);
    assign idx_s    = ADDR[3:1];
    assign wr_s     = WE && sel_s;
    assign rd_s     = RE && sel_s;
    assign unused_s = ADDR[0];

    // Per-bit debounce completion and key press (debounced 1 -> 0) detection.
    always_comb begin
        deb_done_s = '0;
        for (int i = 0; i < 14; i++) begin
            deb_done_s[i] = (sync2_r[i] != deb_r[i]) && (deb_cnt_r[i] == DW'(DEBN - 1));
        end
        press_s = deb_done_s[3:0] & deb_r[3:0];
    end

    // Address-derived strobes and timer wrap condition.
    always_comb begin
        kread_s     = rd_s && (idx_s == 3'd0);
        w1c_s       = wr_s && (idx_s == 3'd2);
        wr_tcnt_s   = wr_s && (idx_s == 3'd3);
        wrap_s      = (tlim_r != '0) && (presc_r == TW'(TICK - 1));
        twrap_set_s = wrap_s && (tcnt_r == tlim_r) && !wr_tcnt_s;
    end

    // Input synchronizers and debounce counters.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync1_r <= IN_RST;
            sync2_r <= IN_RST;
            deb_r   <= IN_RST;
            for (int i = 0; i < 14; i++) deb_cnt_r[i] <= '0;
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
            for (int i = 0; i < 14; i++) begin
                if ((sync2_r[i] == deb_r[i]) || deb_done_s[i]) begin
                    deb_cnt_r[i] <= '0;
                end else begin
                    deb_cnt_r[i] <= deb_cnt_r[i] + 1'b1;
                end
                if (deb_done_s[i]) begin
                    deb_r[i] <= sync2_r[i];
                end
            end
        end
    end

    // Key event register and status flags.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            kdata_r  <= 4'h0;
            kready_r <= 1'b0;
            kovr_r   <= 1'b0;
            twrap_r  <= 1'b0;
        end else begin
            if (|press_s) begin
                kdata_r  <= press_s;
                kready_r <= 1'b1;
            end else if (kread_s || (w1c_s && DIN[0])) begin
                kready_r <= 1'b0;
            end
            if ((|press_s) && kready_r && !kread_s) begin
                kovr_r <= 1'b1;
            end else if (w1c_s && DIN[1]) begin
                kovr_r <= 1'b0;
            end
            // A wrap on the same edge as a W1C keeps the flag set.
            if (twrap_set_s) begin
                twrap_r <= 1'b1;
            end else if (w1c_s && DIN[2]) begin
                twrap_r <= 1'b0;
            end
        end
    end

    // Interval timer: prescaler and TCNT; a TCNT write overrides the increment.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            presc_r <= '0;
            tcnt_r  <= '0;
            tlim_r  <= '0;
        end else begin
            if (wr_tcnt_s) begin
                tcnt_r  <= DIN;
                presc_r <= '0;
            end else if (tlim_r != '0) begin
                presc_r <= wrap_s ? '0 : presc_r + 1'b1;
                if (wrap_s) begin
                    tcnt_r <= (tcnt_r == tlim_r) ? '0 : tcnt_r + 1'b1;
                end
            end
            if (wr_s && (idx_s == 3'd7)) begin
                tlim_r <= DIN;
            end
        end
    end

    // Output registers for LEDs and seven-segment displays.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            hexr_r  <= '0;
            ledrr_r <= 10'h000;
            ledgr_r <= 8'h00;
            hex0_r  <= 7'h7F;
            hex1_r  <= 7'h7F;
            hex2_r  <= 7'h7F;
            hex3_r  <= 7'h7F;
        end else if (wr_s) begin
            case (idx_s)
                3'd4: begin
                    hexr_r <= DIN;
`ifdef IO_HEXDEC_EN
                    hex0_r <= hex_seg(DIN[3:0]);
                    hex1_r <= hex_seg(DIN[7:4]);
                    hex2_r <= hex_seg(DIN[11:8]);
                    hex3_r <= hex_seg(DIN[15:12]);
`else
                    hex0_r <= ~DIN[6:0];
                    hex1_r <= 7'h7F;
                    hex2_r <= 7'h7F;
                    hex3_r <= 7'h7F;
`endif
                end
                3'd5:    ledrr_r <= DIN[9:0];
                3'd6:    ledgr_r <= DIN[7:0];
                default: ledrr_r <= ledrr_r;
            endcase
        end
    end

    // Read data multiplexer; zero whenever the block is not selected.
    always_comb begin
        dout_s = '0;
        if (sel_s) begin
            case (idx_s)
                3'd0:    dout_s[3:0] = kdata_r;
                3'd1:    dout_s[9:0] = deb_r[13:4];
                3'd2:    dout_s[2:0] = {twrap_r, kovr_r, kready_r};
                3'd3:    dout_s      = tcnt_r;
                3'd4:    dout_s      = hexr_r;
                3'd5:    dout_s[9:0] = ledrr_r;
                3'd6:    dout_s[7:0] = ledgr_r;
                3'd7:    dout_s      = tlim_r;
                default: dout_s      = '0;
            endcase
        end else begin
            dout_s = '0;
        end
    end

    assign DOUT = dout_s;
    assign SEL  = sel_s;
    assign LEDR = ledrr_r;
    assign LEDG = ledgr_r;
    assign HEX0 = hex0_r;
    assign HEX1 = hex1_r;
    assign HEX2 = hex2_r;
    assign HEX3 = hex3_r;

endmodule

// File: tb/tb_io_ctrl.sv
// Directed plus randomized bench for io_ctrl with DEBN=4, TICK=3; expectations come from a behavioural model.
module tb_io_ctrl;

    localparam int DEBN = 4;
    localparam int TICK = 3;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [15:0] ADDR, DIN, DOUT;
    logic        WE, RE, SEL;
    logic [3:0]  KEY;
    logic [9:0]  SW, LEDR;
    logic [7:0]  LEDG;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3;

    int errors = 0;
    int checks = 0;

    // Model state for the output registers.
    logic [15:0] hexr_m;
    logic [9:0]  ledr_m;
    logic [7:0]  ledg_m;
    logic        hex_written_m;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    io_ctrl #(.DBITS(16), .DEBN(DEBN), .TICK(TICK)) dut (
        .CLK(CLK), .RESET(RESET), .ADDR(ADDR), .DIN(DIN), .WE(WE), .RE(RE),
        .DOUT(DOUT), .SEL(SEL), .KEY(KEY), .SW(SW), .LEDR(LEDR), .LEDG(LEDG),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk_rd(input string tag, input logic [15:0] a, input logic [15:0] exp_v);
        ADDR = a; RE = 1'b0; WE = 1'b0;
        #1;
        chk(tag, DOUT, exp_v);
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        ADDR = a; DIN = d; WE = 1'b1;
        tick(1);
        WE = 1'b0;
    endtask

    function automatic logic [6:0] exp_hex(input int n);
`ifdef IO_HEXDEC_EN
        logic [15:0] v;
        v = hexr_m;
        if (!hex_written_m) return 7'h7F;
        return seg_tab[v[n*4 +: 4]];
`else
        if (n == 0) return ~hexr_m[6:0];
        return 7'h7F;
`endif
    endfunction

    task automatic chk_outputs(input string tag);
        chk({tag, "_ledr"}, {6'b0, LEDR}, {6'b0, ledr_m});
        chk({tag, "_ledg"}, {8'b0, LEDG}, {8'b0, ledg_m});
        chk({tag, "_hex0"}, {9'b0, HEX0}, {9'b0, exp_hex(0)});
        chk({tag, "_hex1"}, {9'b0, HEX1}, {9'b0, exp_hex(1)});
        chk({tag, "_hex2"}, {9'b0, HEX2}, {9'b0, exp_hex(2)});
        chk({tag, "_hex3"}, {9'b0, HEX3}, {9'b0, exp_hex(3)});
    endtask

    initial begin
        logic [3:0]  m;
        logic [15:0] d, c, l;
        int k, r;

        RESET = 1'b1; ADDR = 16'h0000; DIN = 16'h0000; WE = 1'b0; RE = 1'b0;
        KEY = 4'hF; SW = 10'h000;
        hexr_m = 16'h0000; ledr_m = 10'h000; ledg_m = 8'h00; hex_written_m = 1'b0;
        tick(3);
        RESET = 1'b0;

        // Reset state.
        chk_rd("rst_kdata", 16'hFFF0, 16'h0000);
        chk_rd("rst_swdata", 16'hFFF2, 16'h0000);
        chk_rd("rst_stat", 16'hFFF4, 16'h0000);
        chk_rd("rst_tcnt", 16'hFFF6, 16'h0000);
        chk_outputs("rst");
        ADDR = 16'h1234; #1;
        chk("unsel_sel", {15'b0, SEL}, 16'h0000);
        chk("unsel_dout", DOUT, 16'h0000);
        ADDR = 16'hFFF3; #1;
        chk("odd_sel", {15'b0, SEL}, 16'h0001);

        // KEY[1] press: event lands exactly 2+DEBN cycles after the drop.
        tick(1);
        KEY = 4'b1101;
        tick(1 + DEBN);
        chk_rd("key1_early_stat", 16'hFFF4, 16'h0000);
        tick(1);
        chk_rd("key1_kdata", 16'hFFF0, 16'h0002);
        chk_rd("key1_stat", 16'hFFF4, 16'h0001);
        tick(14);
        ADDR = 16'hFFF0; RE = 1'b1;
        tick(1);
        RE = 1'b0;
        chk_rd("key1_read_clr", 16'hFFF4, 16'h0000);
        KEY = 4'hF;
        tick(10);
        chk_rd("key1_release", 16'hFFF4, 16'h0000);

        // Short glitch shorter than DEBN gives no event.
        KEY = 4'b1101;
        tick(DEBN - 1);
        KEY = 4'hF;
        tick(10);
        chk_rd("glitch_stat", 16'hFFF4, 16'h0000);

        // Two presses without a read: overrun and overwrite.
        KEY = 4'b1110;
        tick(10);
        KEY = 4'b1010;
        tick(10);
        chk_rd("ovr_stat", 16'hFFF4, 16'h0003);
        chk_rd("ovr_kdata", 16'hFFF0, 16'h0004);
        wr(16'hFFF4, 16'h0002);
        chk_rd("ovr_w1c", 16'hFFF4, 16'h0001);
        KEY = 4'hF;
        tick(10);
        wr(16'hFFF4, 16'h0007);
        chk_rd("ovr_clr", 16'hFFF4, 16'h0000);

        // Press coinciding with a KDATA read keeps KREADY and does not flag overrun.
        KEY = 4'b0111;
        tick(10);
        KEY = 4'hF;
        tick(10);
        KEY = 4'b1101;
        tick(1 + DEBN);
        ADDR = 16'hFFF0; RE = 1'b1;
        tick(1);
        RE = 1'b0;
        chk_rd("pr_rd_stat", 16'hFFF4, 16'h0001);
        chk_rd("pr_rd_kdata", 16'hFFF0, 16'h0002);
        KEY = 4'hF;
        tick(10);
        wr(16'hFFF4, 16'h0007);

        // Random key masks.
        for (int t = 0; t < 4; t++) begin
            m = 4'($urandom_range(1, 15));
            KEY = ~m;
            tick(2 + DEBN);
            chk_rd("rkey_kdata", 16'hFFF0, {12'b0, m});
            chk_rd("rkey_stat", 16'hFFF4, 16'h0001);
            KEY = 4'hF;
            tick(10);
            wr(16'hFFF4, 16'h0007);
        end

        // Timer with TLIM=2: TCNT counts (k/TICK) mod (TLIM+1).
        wr(16'hFFFE, 16'h0002);
        for (k = 1; k <= 9; k++) begin
            tick(1);
            chk_rd("tmr_tcnt", 16'hFFF6, 16'((k / TICK) % 3));
            chk_rd("tmr_stat", 16'hFFF4, (k / TICK > 2) ? 16'h0004 : 16'h0000);
        end
        wr(16'hFFF4, 16'h0004);
        chk_rd("tmr_w1c", 16'hFFF4, 16'h0000);
        tick(7);
        wr(16'hFFF4, 16'h0004);
        chk_rd("tmr_set_wins", 16'hFFF4, 16'h0004);
        chk_rd("tmr_wrap_tcnt", 16'hFFF6, 16'h0000);
        wr(16'hFFFE, 16'h0000);
        wr(16'hFFF4, 16'h0004);
        tick(5);
        chk_rd("tmr_hold_tcnt", 16'hFFF6, 16'h0000);
        chk_rd("tmr_hold_stat", 16'hFFF4, 16'h0000);

        // Random timer trials.
        for (int t = 0; t < 4; t++) begin
            l = 16'($urandom_range(1, 5));
            c = 16'($urandom_range(0, int'(l)));
            k = $urandom_range(0, 20);
            wr(16'hFFF6, c);
            wr(16'hFFF4, 16'h0004);
            wr(16'hFFFE, l);
            tick(k);
            chk_rd("rtmr_tlim", 16'hFFFE, l);
            chk_rd("rtmr_tcnt", 16'hFFF6, 16'((int'(c) + k / TICK) % (int'(l) + 1)));
            chk_rd("rtmr_stat", 16'hFFF4, (int'(c) + k / TICK > int'(l)) ? 16'h0004 : 16'h0000);
            wr(16'hFFFE, 16'h0000);
            wr(16'hFFF4, 16'h0004);
        end

        // LED and HEX registers.
        wr(16'hFFFA, 16'hFFFF); ledr_m = 10'h3FF;
        chk_rd("ledr_rd", 16'hFFFA, 16'h03FF);
        wr(16'hFFFC, 16'hFFFF); ledg_m = 8'hFF;
        wr(16'hFFF8, 16'h1234); hexr_m = 16'h1234; hex_written_m = 1'b1;
        chk_rd("hexr_rd", 16'hFFF8, 16'h1234);
        chk_outputs("dir");
        for (int t = 0; t < 6; t++) begin
            r = $urandom_range(0, 2);
            d = 16'($urandom);
            case (r)
                0: begin wr(16'hFFF8, d); hexr_m = d; hex_written_m = 1'b1; end
                1: begin wr(16'hFFFA, d); ledr_m = d[9:0]; end
                default: begin wr(16'hFFFC, d); ledg_m = d[7:0]; end
            endcase
            chk_outputs("rnd");
            chk_rd("rnd_hexr", 16'hFFF8, hexr_m);
            chk_rd("rnd_ledr", 16'hFFFA, {6'b0, ledr_m});
            chk_rd("rnd_ledg", 16'hFFFC, {8'b0, ledg_m});
        end

        // Reset in the middle of an SW[9] debounce discards progress.
        SW = 10'h200;
        tick(3);
        RESET = 1'b1;
        tick(2);
        RESET = 1'b0;
        hexr_m = 16'h0000; ledr_m = 10'h000; ledg_m = 8'h00; hex_written_m = 1'b0;
        chk_rd("swr_after_rst", 16'hFFF2, 16'h0000);
        chk_outputs("swr");
        chk_rd("swr_stat", 16'hFFF4, 16'h0000);
        tick(1 + DEBN);
        chk_rd("swr_early", 16'hFFF2, 16'h0000);
        tick(1);
        chk_rd("swr_done", 16'hFFF2, 16'h0200);
        chk_rd("swr_no_key", 16'hFFF4, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
